multicycle_controller: RTL and testbench

//  Sequencing FSM for the multicycle RV32I core (add/sub/and/or/slt, addi-class, lw, sw, beq, jal).

---
 rtl/multicycle_controller.sv | 190 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle RV32I core: walks the shared ALU, unified memory
// port, register file and PC/IR through 3-5 cycles per instruction, with mem_ready stalls.
module multicycle_controller #(
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       addr_select,
  output logic       IR_write,
  output logic       PC_write,
  output logic       reg_write,
  output logic [1:0] ALU_src_A,
  output logic [1:0] ALU_src_B,
  output logic [2:0] ALU_control,
  output logic [1:0] result_select,
  output logic       instr_done,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXEC_R, S_EXEC_I, S_JAL, S_ALUWB, S_BEQ, S_ILLEGAL
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] A_PC    = 2'b00;
  localparam logic [1:0] A_OLDPC = 2'b01;
  localparam logic [1:0] A_RS1   = 2'b10;
  localparam logic [1:0] B_RS2   = 2'b00;
  localparam logic [1:0] B_IMM   = 2'b01;
  localparam logic [1:0] B_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  state_t     state, state_nxt;
  logic [2:0] alu_dec;
  logic       rd_raw, wr_raw, irw_raw, pcw_raw, rw_raw, done_raw;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_nxt;
  end

  // Only register-register ops with funct7b5 subtract; addi with IR[30] set stays an add.
  always_comb begin
    alu_dec = ALU_ADD;
    case (funct3)
      3'b000:  alu_dec = (opcode[5] & funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_dec = ALU_SLT;
      3'b110:  alu_dec = ALU_OR;
      3'b111:  alu_dec = ALU_AND;
      default: alu_dec = ALU_ADD;
    endcase
  end

  always_comb begin
    state_nxt     = state;
    rd_raw        = 1'b0;
    wr_raw        = 1'b0;
    irw_raw       = 1'b0;
    pcw_raw       = 1'b0;
    rw_raw        = 1'b0;
    done_raw      = 1'b0;
    addr_select   = 1'b0;
    ALU_src_A     = A_PC;
    ALU_src_B     = B_RS2;
    ALU_control   = ALU_ADD;
    result_select = RES_ALUOUT;
    illegal       = 1'b0;
    case (state)
      S_FETCH: begin
        rd_raw = 1'b1;
        if (mem_ready) begin
          irw_raw       = 1'b1;
          pcw_raw       = 1'b1;
          ALU_src_A     = A_PC;
          ALU_src_B     = B_FOUR;
          result_select = RES_ALU;
          state_nxt     = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch/jump target is computed speculatively into ALUOut here.
        ALU_src_A = A_OLDPC;
        ALU_src_B = B_IMM;
        case (opcode)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_R:         state_nxt = S_EXEC_R;
          OP_I:         state_nxt = S_EXEC_I;
          OP_JAL:       state_nxt = S_JAL;
          OP_BEQ:       state_nxt = S_BEQ;
          default:      state_nxt = ILLEGAL_TRAP ? S_ILLEGAL : S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALU_src_A = A_RS1;
        ALU_src_B = B_IMM;
        state_nxt = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        addr_select = 1'b1;
        rd_raw      = 1'b1;
        if (mem_ready) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        result_select = RES_MEM;
        rw_raw        = 1'b1;
        done_raw      = 1'b1;
        state_nxt     = S_FETCH;
      end
      S_MEMWRITE: begin
        addr_select = 1'b1;
        wr_raw      = 1'b1;
        if (mem_ready) begin
          done_raw  = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_EXEC_R: begin
        ALU_src_A   = A_RS1;
        ALU_src_B   = B_RS2;
        ALU_control = alu_dec;
        state_nxt   = S_ALUWB;
      end
      S_EXEC_I: begin
        ALU_src_A   = A_RS1;
        ALU_src_B   = B_IMM;
        ALU_control = alu_dec;
        state_nxt   = S_ALUWB;
      end
      S_JAL: begin
        // PC takes the target held in ALUOut while the ALU forms old_PC+4 for rd.
        ALU_src_A     = A_OLDPC;
        ALU_src_B     = B_FOUR;
        result_select = RES_ALUOUT;
        pcw_raw       = 1'b1;
        state_nxt     = S_ALUWB;
      end
      S_ALUWB: begin
        result_select = RES_ALUOUT;
        rw_raw        = 1'b1;
        done_raw      = 1'b1;
        state_nxt     = S_FETCH;
      end
      S_BEQ: begin
        ALU_src_A     = A_RS1;
        ALU_src_B     = B_RS2;
        ALU_control   = ALU_SUB;
        result_select = RES_ALUOUT;
        pcw_raw       = zero;
        done_raw      = 1'b1;
        state_nxt     = S_FETCH;
      end
      S_ILLEGAL: begin
        illegal = 1'b1;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // Strobes are gated by reset directly so they drop the moment reset falls.
  assign mem_read   = rd_raw   & reset;
  assign mem_write  = wr_raw   & reset;
  assign IR_write   = irw_raw  & reset;
  assign PC_write   = pcw_raw  & reset;
  assign reg_write  = rw_raw   & reset;
  assign instr_done = done_raw & reset;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed cases with literal expectations, then random
// instruction streams checked every cycle against a phase-list model, for both trap settings.
module tb_multicycle_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       funct7b5 = 1'b0, zero = 1'b0, mem_ready = 1'b0;

  typedef struct packed {
    logic       mem_read, mem_write, addr_select, IR_write, PC_write, reg_write;
    logic [1:0] a, b;
    logic [2:0] alu;
    logic [1:0] res;
    logic       done, illegal;
  } ctrl_t;

  logic mr_t, mw_t, as_t, irw_t, pcw_t, rw_t, dn_t, il_t;
  logic mr_n, mw_n, as_n, irw_n, pcw_n, rw_n, dn_n, il_n;
  logic [1:0] a_t, b_t, rs_t, a_n, b_n, rs_n;
  logic [2:0] alu_t, alu_n;
  ctrl_t got [2];

  assign got[0] = {mr_t, mw_t, as_t, irw_t, pcw_t, rw_t, a_t, b_t, alu_t, rs_t, dn_t, il_t};
  assign got[1] = {mr_n, mw_n, as_n, irw_n, pcw_n, rw_n, a_n, b_n, alu_n, rs_n, dn_n, il_n};

  multicycle_controller #(.ILLEGAL_TRAP(1'b1)) dut_t (
    .clock(clock), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .mem_read(mr_t), .mem_write(mw_t),
    .addr_select(as_t), .IR_write(irw_t), .PC_write(pcw_t), .reg_write(rw_t),
    .ALU_src_A(a_t), .ALU_src_B(b_t), .ALU_control(alu_t), .result_select(rs_t),
    .instr_done(dn_t), .illegal(il_t));

  multicycle_controller #(.ILLEGAL_TRAP(1'b0)) dut_n (
    .clock(clock), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .mem_read(mr_n), .mem_write(mw_n),
    .addr_select(as_n), .IR_write(irw_n), .PC_write(pcw_n), .reg_write(rw_n),
    .ALU_src_A(a_n), .ALU_src_B(b_n), .ALU_control(alu_n), .result_select(rs_n),
    .instr_done(dn_n), .illegal(il_n));

  initial forever #5 clock = ~clock;

  int nvec = 0, nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: current phase plus the phases the instruction still has to visit.
  // Index 0 models the trapping instance, index 1 the non-trapping one.
  string ph [2] = '{"F", "F"};
  string p1 [2] = '{"", ""};
  string p2 [2] = '{"", ""};

  task automatic step(input string cur, input string n1, input string n2, input logic [6:0] op,
                      input logic rdy, input bit trap, output string o0, output string o1,
                      output string o2);
    o0 = cur; o1 = n1; o2 = n2;
    if (cur == "F") begin
      if (rdy) o0 = "D";
    end else if (cur == "D") begin
      o1 = ""; o2 = "";
      case (op)
        7'b0000011: begin o0 = "MA"; o1 = "MR"; o2 = "MWB"; end
        7'b0100011: begin o0 = "MA"; o1 = "MW"; end
        7'b0110011: begin o0 = "ER"; o1 = "WB"; end
        7'b0010011: begin o0 = "EI"; o1 = "WB"; end
        7'b1101111: begin o0 = "J";  o1 = "WB"; end
        7'b1100011: o0 = "B";
        default:    o0 = trap ? "ILL" : "F";
      endcase
    end else if (cur == "ILL") begin
      o0 = "ILL";
    end else if ((cur == "MR" || cur == "MW") && !rdy) begin
      o0 = cur;
    end else begin
      o0 = (n1 == "") ? "F" : n1; o1 = n2; o2 = "";
    end
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int m = 0; m < 2; m++) begin ph[m] <= "F"; p1[m] <= ""; p2[m] <= ""; end
    end else begin
      for (int m = 0; m < 2; m++) begin
        string x0, x1, x2;
        step(ph[m], p1[m], p2[m], opcode, mem_ready, (m == 0), x0, x1, x2);
        ph[m] <= x0; p1[m] <= x1; p2[m] <= x2;
      end
    end
  end

  function automatic logic [2:0] alu_of(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0:    return (op[5] && f7) ? 3'b001 : 3'b000;
      3'd2:    return 3'b101;
      3'd6:    return 3'b011;
      3'd7:    return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic ctrl_t expect_ctrl(input string p, input logic rdy, input logic z, input logic rst);
    ctrl_t c = '0;
    case (p)
      "F":   begin c.mem_read = 1; if (rdy) begin c.IR_write = 1; c.PC_write = 1; c.b = 2; c.res = 2; end end
      "D":   begin c.a = 1; c.b = 1; end
      "MA":  begin c.a = 2; c.b = 1; end
      "MR":  begin c.addr_select = 1; c.mem_read = 1; end
      "MWB": begin c.res = 1; c.reg_write = 1; c.done = 1; end
      "MW":  begin c.addr_select = 1; c.mem_write = 1; c.done = rdy; end
      "ER":  begin c.a = 2; c.b = 0; c.alu = alu_of(opcode, funct3, funct7b5); end
      "EI":  begin c.a = 2; c.b = 1; c.alu = alu_of(opcode, funct3, funct7b5); end
      "J":   begin c.a = 1; c.b = 2; c.PC_write = 1; end
      "WB":  begin c.reg_write = 1; c.done = 1; end
      "B":   begin c.a = 2; c.alu = 3'b001; c.PC_write = z; c.done = 1; end
      "ILL": c.illegal = 1;
      default: ;
    endcase
    if (!rst) begin
      c.mem_read = 0; c.mem_write = 0; c.IR_write = 0; c.PC_write = 0; c.reg_write = 0; c.done = 0;
    end
    return c;
  endfunction

  always @(negedge clock) begin
    for (int m = 0; m < 2; m++)
      chk($sformatf("ctrl%0d_%s", m, ph[m]), 32'(got[m]),
          32'(expect_ctrl(ph[m], mem_ready, zero, reset)));
  end

  task automatic load(input logic [31:0] ir);
    opcode = ir[6:0]; funct3 = ir[14:12]; funct7b5 = ir[30];
  endtask

  // Per-cycle samples of a directed run (bit c = cycle c of the instruction).
  logic [15:0] s_mr, s_mw, s_as, s_pcw, s_rw, s_dn, s_il, s_irw, s_mrn, s_any;
  logic [2:0]  s_alu [16];
  logic [1:0]  s_res [16];

  task automatic run(input logic [31:0] ir, input int n, input logic [15:0] rdy, input logic z);
    load(ir);
    for (int c = 0; c < n; c++) begin
      @(posedge clock); #1;
      mem_ready = rdy[c]; zero = z;
      @(negedge clock);
      s_mr[c] = mr_t; s_mw[c] = mw_t; s_as[c] = as_t; s_pcw[c] = pcw_t; s_rw[c] = rw_t;
      s_dn[c] = dn_t; s_il[c] = il_t; s_irw[c] = irw_t; s_mrn[c] = mr_n;
      s_any[c] = mr_t | mw_t | irw_t | pcw_t | rw_t | dn_t;
      s_alu[c] = alu_t; s_res[c] = rs_t;
    end
  endtask

  initial begin
    int illcnt;
    logic [6:0] badop [4];
    badop = '{7'h7F, 7'h37, 7'h17, 7'h00};

    repeat (2) @(negedge clock);
    chk("rst_mem_read", {30'd0, mr_t, mr_n}, 0);
    chk("rst_strobes", {27'd0, irw_t, pcw_t, rw_t, dn_t, mw_t}, 0);
    @(posedge clock); #1 reset = 1'b1;
    @(negedge clock);
    chk("release_fetch_req", {31'd0, mr_t}, 1);

    run(32'h002081B3, 4, 16'hFFFF, 0);
    chk("add_fetch_irw", {31'd0, s_irw[0]}, 1);
    chk("add_rw_cycle4", {28'd0, s_rw[3:0]}, 32'b1000);
    chk("add_done_once", {28'd0, s_dn[3:0]}, 32'b1000);
    chk("add_alu", {29'd0, s_alu[2]}, 0);

    run(32'h0000A103, 7, 16'hFFE7, 0);
    chk("lw_req_held", $countones(s_mr[6:0] & s_as[6:0]), 3);
    chk("lw_res_mem", {30'd0, s_res[6]}, 1);
    chk("lw_done_c7", {25'd0, s_dn[6:0]}, 32'b1000000);

    run(32'h00208063, 3, 16'hFFFF, 1);
    chk("beq_taken_pcw", {31'd0, s_pcw[2]}, 1);
    chk("beq_taken_alu", {29'd0, s_alu[2]}, 1);
    chk("beq_taken_done", {29'd0, s_dn[2:0]}, 32'b100);
    run(32'h00208063, 3, 16'hFFFF, 0);
    chk("beq_nt_pcw", {31'd0, s_pcw[2]}, 0);
    chk("beq_nt_alu", {29'd0, s_alu[2]}, 1);

    run(32'h40208033, 4, 16'hFFFF, 0);
    chk("sub_alu", {29'd0, s_alu[2]}, 1);
    run(32'h40008093, 4, 16'hFFFF, 0);
    chk("addi_ir30_alu", {29'd0, s_alu[2]}, 0);
    run(32'h0020A093, 4, 16'hFFFF, 0);
    chk("slti_alu", {29'd0, s_alu[2]}, 5);

    run(32'h0000007F, 13, 16'hFFFF, 0);
    chk("ill_flag", {21'd0, s_il[12:2]}, 32'h7FF);
    chk("ill_no_strobe", {21'd0, s_any[12:2]}, 0);
    chk("ill_notrap_fetch", {31'd0, s_mrn[2]}, 1);

    @(posedge clock); #1 reset = 1'b0; mem_ready = 1'b0;
    @(posedge clock); #1 reset = 1'b1;
    run(32'h0020A023, 4, 16'hFFF7, 0);
    chk("sw_mem_write", {31'd0, s_mw[3]}, 1);
    #1 reset = 1'b0;
    #1 chk("sw_async_drop", {30'd0, mw_t, mw_n}, 0);
    mem_ready = 1'b1;
    @(posedge clock); #1 reset = 1'b1;
    #1 chk("sw_refetch", {31'd0, mr_t}, 1);

    illcnt = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clock); #1;
      mem_ready = ($urandom % 3) != 0;
      zero = 1'($urandom);
      if (ph[1] == "D") begin
        int k;
        k = $urandom % 16;
        funct3 = 3'($urandom); funct7b5 = 1'($urandom);
        if (k < 4)       opcode = 7'b0110011;
        else if (k < 7)  opcode = 7'b0010011;
        else if (k < 9)  opcode = 7'b0000011;
        else if (k < 11) opcode = 7'b0100011;
        else if (k < 13) opcode = 7'b1100011;
        else if (k < 15) opcode = 7'b1101111;
        else             opcode = badop[$urandom % 4];
      end
      if (ph[0] == "ILL") illcnt++;
      if (illcnt >= 10 || ($urandom % 300) == 0) begin
        illcnt = 0;
        reset = 1'b0;
        @(negedge clock);
        #3 reset = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
